// File: rtl/dram_pkg.sv
// rtl/dram_pkg.sv - command-FSM state encoding shared by the DRAM controller
package dram_pkg;
   typedef enum logic [2:0] {
      IDLE,
      INIT,
      ACTIVATE,
      READ,
      WRITE,
      PRECHARGE,
      REFRESH,
      NOP
   } dram_state_t;
endpackage

// File: rtl/dram_timing_ctrl.sv
// rtl/dram_timing_ctrl.sv - command-to-command delay timer and tREFI refresh request generator
// Optional: DRAM_REF_POSTPONE_EN turns the pending-refresh flag into a saturating postponement counter.
module dram_timing_ctrl
   import dram_pkg::*;
#(
   parameter int tRCD  = 14,
   parameter int tRD   = 22,
   parameter int tWR   = 34,
   parameter int tRP   = 14,
   parameter int tRFC  = 280,
   parameter int tREFI = 3120,
   parameter int CNT_W = 12
) (
   input  logic        CLK,
   input  logic        RST,
   input  dram_state_t state,
   input  dram_state_t nstate,
   input  logic        init_done,
   input  logic        clear,
   output logic        tACT_done,
   output logic        tRD_done,
   output logic        tWR_done,
   output logic        tPRE_done,
   output logic        tREF_done,
   output logic        rf_req,
   output logic        rf_urgent
);

   // A zero parameter behaves as one cycle, so both load the terminal count directly.
   function automatic logic [CNT_W-1:0] last_of(input int t);
      return (t <= 1) ? '0 : CNT_W'(t - 1);
   endfunction

   function automatic logic is_timed(input dram_state_t s);
      return (s == ACTIVATE) || (s == READ) || (s == WRITE) ||
             (s == PRECHARGE) || (s == REFRESH);
   endfunction

   localparam logic [CNT_W-1:0] REFI_LAST = last_of(tREFI);

   logic [CNT_W-1:0] tcnt;
   logic [CNT_W-1:0] ld_val;
   dram_state_t      tsel;
   logic             active;
   logic             load;
   logic             strobe;
   logic [CNT_W-1:0] refi_cnt;
   logic             tick;
   logic             issued;

   assign load = (nstate != state) && is_timed(nstate);

   always_comb begin
      ld_val = '0;
      case (nstate)
         ACTIVATE:  ld_val = last_of(tRCD);
         READ:      ld_val = last_of(tRD);
         WRITE:     ld_val = last_of(tWR);
         PRECHARGE: ld_val = last_of(tRP);
         REFRESH:   ld_val = last_of(tRFC);
         default:   ld_val = '0;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         tcnt   <= '0;
         tsel   <= IDLE;
         active <= 1'b0;
      end else if (clear) begin
         active <= 1'b0;
      end else if (load) begin
         tcnt   <= ld_val;
         tsel   <= nstate;
         active <= 1'b1;
      end else if (active) begin
         if (tcnt != '0)
            tcnt <= tcnt - CNT_W'(1);
         else
            active <= 1'b0;
      end
   end

   // clear masks the strobe in the same cycle; it is the only combinational input path.
   assign strobe    = active && (tcnt == '0) && !clear;
   assign tACT_done = strobe && (tsel == ACTIVATE);
   assign tRD_done  = strobe && (tsel == READ);
   assign tWR_done  = strobe && (tsel == WRITE);
   assign tPRE_done = strobe && (tsel == PRECHARGE);
   assign tREF_done = strobe && (tsel == REFRESH);

   assign tick   = init_done && (refi_cnt == REFI_LAST);
   assign issued = (nstate == REFRESH) && (state != REFRESH);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         refi_cnt <= '0;
      else if (!init_done || tick)
         refi_cnt <= '0;
      else
         refi_cnt <= refi_cnt + CNT_W'(1);
   end

`ifdef DRAM_REF_POSTPONE_EN
   logic [3:0] pending;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         pending <= 4'd0;
      else if (tick && !issued && (pending != 4'd8))
         pending <= pending + 4'd1;
      else if (issued && !tick && (pending != 4'd0))
         pending <= pending - 4'd1;
   end

   assign rf_req    = (pending != 4'd0);
   assign rf_urgent = (pending == 4'd8);
`else
   logic pending;

   // A tick coinciding with an issued refresh keeps the request alive.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         pending <= 1'b0;
      else if (tick)
         pending <= 1'b1;
      else if (issued)
         pending <= 1'b0;
   end

   assign rf_req    = pending;
   assign rf_urgent = 1'b0;
`endif

endmodule
